// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte requesters.
// Optional build macro LOCK_TIMEOUT_EN aborts a packet lock whose owner goes quiet.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_WAIT    = 4,
    parameter int LOCK_IDLE_MAX = 16,
    localparam int OW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_last,
    input  logic [8*NUM_REQ-1:0] i_data,
    output logic [NUM_REQ-1:0]   o_ack,
    input  logic                 i_tx_ready,
    output logic                 o_tx_isNew,
    output logic [7:0]           o_tx_message,
    output logic [OW-1:0]        o_owner,
    output logic                 o_busy,
    output logic [15:0]          o_byte_count,
    output logic                 o_lock_abort
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_START = 2'd1;
    localparam logic [1:0] S_WAIT_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [OW-1:0]      r_ptr;
    logic               r_locked;
    logic [OW-1:0]      r_owner;
    logic               r_tx_isNew;
    logic [7:0]         r_tx_message;
    logic [NUM_REQ-1:0] r_ack;
    logic [15:0]        r_byte_count;
    logic [7:0]         r_start_cnt;

    logic               w_found;
    logic               w_grant;
    logic [OW-1:0]      w_winner;
    logic [OW-1:0]      w_idx;
    logic [OW-1:0]      w_winner_next;
    logic [OW-1:0]      w_owner_next;
    int                 w_sum;

    // A lock restricts the candidate set to the current owner only.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = '0;
        w_sum    = 0;
        if (r_locked) begin
            w_found  = i_req[r_owner];
            w_winner = r_owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_sum = int'(r_ptr) + k;
                if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
                w_idx = OW'(w_sum);
                if (!w_found && i_req[w_idx]) begin
                    w_found  = 1'b1;
                    w_winner = w_idx;
                end
            end
        end
    end

    assign w_grant       = (r_state == S_IDLE) && i_tx_ready && w_found;
    assign w_winner_next = (int'(w_winner) == NUM_REQ - 1) ? '0 : OW'(w_winner + 1'b1);
    assign w_owner_next  = (int'(r_owner) == NUM_REQ - 1) ? '0 : OW'(r_owner + 1'b1);

`ifdef LOCK_TIMEOUT_EN
    logic [15:0] r_lock_cnt;
    logic        r_lock_abort;
    logic        w_lock_idle;
    logic        w_abort;

    assign w_lock_idle = (r_state == S_IDLE) && r_locked && !i_req[r_owner];
    assign w_abort     = w_lock_idle && (r_lock_cnt == 16'(LOCK_IDLE_MAX - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lock_cnt <= '0;
        end else if (w_lock_idle && !w_abort) begin
            r_lock_cnt <= r_lock_cnt + 16'd1;
        end else begin
            r_lock_cnt <= '0;
        end
    end

    assign o_lock_abort = r_lock_abort;
`else
    logic w_unused_lock_max;
    assign w_unused_lock_max = ^LOCK_IDLE_MAX;
    assign o_lock_abort      = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_locked     <= 1'b0;
            r_owner      <= '0;
            r_tx_isNew   <= 1'b0;
            r_tx_message <= 8'h00;
            r_ack        <= '0;
            r_byte_count <= 16'h0000;
            r_start_cnt  <= 8'd0;
`ifdef LOCK_TIMEOUT_EN
            r_lock_abort <= 1'b0;
`endif
        end else begin
            r_tx_isNew <= 1'b0;
            r_ack      <= '0;
`ifdef LOCK_TIMEOUT_EN
            r_lock_abort <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_tx_message    <= i_data[{w_winner, 3'b000} +: 8];
                        r_tx_isNew      <= 1'b1;
                        r_ack[w_winner] <= 1'b1;
                        r_owner         <= w_winner;
                        r_byte_count    <= r_byte_count + 16'd1;
                        r_start_cnt     <= 8'd0;
                        r_state         <= S_WAIT_START;
                        if (i_last[w_winner]) begin
                            r_locked <= 1'b0;
                            r_ptr    <= w_winner_next;
                        end else begin
                            r_locked <= 1'b1;
                        end
                    end
`ifdef LOCK_TIMEOUT_EN
                    else if (w_abort) begin
                        r_locked     <= 1'b0;
                        r_ptr        <= w_owner_next;
                        r_lock_abort <= 1'b1;
                    end
`endif
                end
                S_WAIT_START: begin
                    // Watchdog covers a transmitter that never visibly drops ready.
                    if (!i_tx_ready || (r_start_cnt == 8'(START_WAIT - 1))) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_start_cnt <= r_start_cnt + 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_tx_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ack        = r_ack;
    assign o_tx_isNew   = r_tx_isNew;
    assign o_tx_message = r_tx_message;
    assign o_owner      = r_owner;
    assign o_byte_count = r_byte_count;
    assign o_busy       = (r_state != S_IDLE) || r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with an inline transmitter model.
module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    logic [3:0]  last  = '0;
    logic [31:0] data  = '0;
    logic        tx_ready = 1'b1;
    logic [3:0]  ack;
    logic        tx_isNew;
    logic [7:0]  tx_message;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] byte_count;
    logic        lock_abort;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .START_WAIT(4),
        .LOCK_IDLE_MAX(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .i_req(req),
        .i_last(last),
        .i_data(data),
        .o_ack(ack),
        .i_tx_ready(tx_ready),
        .o_tx_isNew(tx_isNew),
        .o_tx_message(tx_message),
        .o_owner(owner),
        .o_busy(busy),
        .o_byte_count(byte_count),
        .o_lock_abort(lock_abort)
    );

    int checks = 0;
    int errors = 0;
    int tx_mode = 1;
    int tx_t = 0;
    int cyc_no = 0;
    int n_strobe, n_ack_cyc, n_b2b, n_idle, n_abort;
    logic        prev_new;
    logic [15:0] bc_abort;
    logic [1:0]  s_owner [16];
    logic [7:0]  s_msg   [16];
    logic [3:0]  s_ack   [16];
    int          s_cyc   [16];
    int          s_idle  [16];
    int          step;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        n_strobe  = 0;
        n_ack_cyc = 0;
        n_b2b     = 0;
        n_idle    = 0;
        n_abort   = 0;
        prev_new  = 1'b0;
        bc_abort  = '0;
    endtask

    // One clock: sample just after the edge, log strobes, then advance the transmitter model.
    task automatic cyc();
        @(posedge clock);
        #1;
        cyc_no++;
        if (ack != 4'b0) n_ack_cyc++;
        if (tx_isNew) begin
            if (prev_new) n_b2b++;
            if (n_strobe < 16) begin
                s_owner[n_strobe] = owner;
                s_msg[n_strobe]   = tx_message;
                s_ack[n_strobe]   = ack;
                s_cyc[n_strobe]   = cyc_no;
                s_idle[n_strobe]  = n_idle;
            end
            n_strobe++;
        end
        prev_new = tx_isNew;
        if (!busy) n_idle++;
        if (lock_abort) begin
            n_abort++;
            bc_abort = byte_count;
        end
        if (tx_mode == 1) begin
            if (tx_isNew) tx_t = 1;
            else if (tx_t > 0) tx_t++;
            if (tx_t >= 13) tx_t = 0;
            tx_ready = !(tx_t >= 3);
        end else begin
            tx_ready = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        last     = '0;
        data     = '0;
        tx_t     = 0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        clr_log();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && busy; i++) cyc();
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        clr_log();
        // Reset state
        @(posedge clock);
        #1;
        chk("rst_isNew", 32'(tx_isNew), 32'd0);
        chk("rst_msg", 32'(tx_message), 32'h00);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bc", 32'(byte_count), 32'd0);
        chk("rst_abort", 32'(lock_abort), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single byte from requester 0
        tx_mode = 1;
        req = 4'b0001; last = 4'b0001; data[7:0] = 8'h41;
        for (int i = 0; i < 20 && n_strobe == 0; i++) cyc();
        req = '0;
        chk("t1_strobe", 32'(n_strobe), 32'd1);
        chk("t1_msg", 32'(tx_message), 32'h41);
        chk("t1_ack", 32'(ack), 32'b0001);
        chk("t1_owner", 32'(owner), 32'd0);
        chk("t1_bc", 32'(byte_count), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1_idle");
        chk("t1_busy_cycles", 32'(cyc_no - s_cyc[0]), 32'd13);
        chk("t1_one_byte", 32'(n_strobe), 32'd1);

        // Round robin among 0,1,2
        do_reset();
        req = 4'b0111; last = 4'b1111; data = 32'hA3A2A1A0;
        for (int i = 0; i < 300 && n_strobe < 6; i++) cyc();
        req = '0;
        chk("t2_count", 32'(n_strobe), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("t2_owner", 32'(s_owner[i]), 32'(i % 3));
            chk("t2_msg", 32'(s_msg[i]), 32'(8'hA0 + (i % 3)));
            chk("t2_ack", 32'(s_ack[i]), 32'(1 << (i % 3)));
        end
        wait_idle("t2_idle");
        chk("t2_ack_cycles", 32'(n_ack_cyc), 32'd6);
        chk("t2_b2b", 32'(n_b2b), 32'd0);
        chk("t2_no_extra", 32'(n_strobe), 32'd6);

        // Locked 3-byte packet from requester 1 while requester 0 waits
        do_reset();
        req = 4'b0010; last = 4'b0000; data[15:8] = 8'h10; data[7:0] = 8'h55;
        step = 0;
        for (int i = 0; i < 400 && n_strobe < 4; i++) begin
            cyc();
            if (ack[1]) begin
                step++;
                if (step == 1) begin
                    req[0] = 1'b1; last[0] = 1'b1; data[15:8] = 8'h11;
                end else if (step == 2) begin
                    data[15:8] = 8'h12; last[1] = 1'b1;
                end else begin
                    req[1] = 1'b0;
                end
            end
            if (ack[0]) req[0] = 1'b0;
        end
        chk("t3_count", 32'(n_strobe), 32'd4);
        chk("t3_msg0", 32'(s_msg[0]), 32'h10);
        chk("t3_msg1", 32'(s_msg[1]), 32'h11);
        chk("t3_msg2", 32'(s_msg[2]), 32'h12);
        chk("t3_msg3", 32'(s_msg[3]), 32'h55);
        chk("t3_owner2", 32'(s_owner[2]), 32'd1);
        chk("t3_owner3", 32'(s_owner[3]), 32'd0);
        wait_idle("t3_idle");

        // Transmitter never drops ready: watchdog exit
        do_reset();
        tx_mode = 0;
        req = 4'b0001; last = 4'b0001; data[7:0] = 8'h77;
        for (int i = 0; i < 40 && n_strobe < 2; i++) cyc();
        req = '0;
        chk("t4_count", 32'(n_strobe), 32'd2);
        chk("t4_msg", 32'(s_msg[1]), 32'h77);
        chk("t4_gap", 32'(s_cyc[1] - s_cyc[0]), 32'd6);
        chk("t4_idle_between", 32'(s_idle[1] - s_idle[0]), 32'd1);
        wait_idle("t4_idle");

        // Async reset in WAIT_DONE with a lock held
        do_reset();
        tx_mode = 1;
        req = 4'b0010; last = 4'b0010; data[15:8] = 8'h5A;
        for (int i = 0; i < 20 && n_strobe < 1; i++) cyc();
        req = '0;
        wait_idle("t5_idle");
        req = 4'b0100; last = 4'b0000; data[23:16] = 8'h66;
        for (int i = 0; i < 20 && n_strobe < 2; i++) cyc();
        req = '0;
        chk("t5_owner_before", 32'(owner), 32'd2);
        repeat (4) cyc();
        chk("t5_busy_before", 32'(busy), 32'd1);
        chk("t5_ready_low", 32'(tx_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_isNew", 32'(tx_isNew), 32'd0);
        chk("t5_msg", 32'(tx_message), 32'h00);
        chk("t5_owner", 32'(owner), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_bc", 32'(byte_count), 32'd0);
        chk("t5_ack", 32'(ack), 32'd0);
        chk("t5_abort", 32'(lock_abort), 32'd0);
        tx_t = 0;
        tx_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clr_log();
        req = 4'b1010; last = 4'b1010; data[15:8] = 8'h21; data[31:24] = 8'h33;
        for (int i = 0; i < 20 && n_strobe < 1; i++) cyc();
        req = '0;
        chk("t5_after_count", 32'(n_strobe), 32'd1);
        chk("t5_after_owner", 32'(s_owner[0]), 32'd1);
        chk("t5_after_msg", 32'(s_msg[0]), 32'h21);
        wait_idle("t5_after_idle");

        // Locked owner goes quiet while requester 3 waits
        do_reset();
        tx_mode = 1;
        req = 4'b0100; last = 4'b0000; data[23:16] = 8'h22;
        for (int i = 0; i < 20 && n_strobe < 1; i++) cyc();
        req = '0;
        req[3] = 1'b1; last[3] = 1'b1; data[31:24] = 8'h99;
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (ack[3]) req[3] = 1'b0;
        end
`ifdef LOCK_TIMEOUT_EN
        chk("t6_abort_pulses", 32'(n_abort), 32'd1);
        chk("t6_bc_at_abort", 32'(bc_abort), 32'd1);
        chk("t6_count", 32'(n_strobe), 32'd2);
        chk("t6_owner", 32'(s_owner[1]), 32'd3);
        chk("t6_msg", 32'(s_msg[1]), 32'h99);
        chk("t6_bc", 32'(byte_count), 32'd2);
`else
        chk("t6_abort_pulses", 32'(n_abort), 32'd0);
        chk("t6_count", 32'(n_strobe), 32'd1);
        chk("t6_bc", 32'(byte_count), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_owner", 32'(owner), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (byte-wide, one-cycle isNew strobe, ready-when-idle) among NUM_REQ on-chip requesters. Each requester supplies one byte at a time, flagged as the last byte of its packet. Arbitration is round-robin, and a multi-byte packet holds the transmitter until its last byte. Sits between requesters (echo logic, status reporters, etc.) and the transmitter wrapper in the chip top level.

Parameters:
NUM_REQ, 4, number of requesters; legal range 1..8.
START_WAIT, 4, max cycles to wait for tx_ready to fall after a strobe before treating the byte as accepted; legal range 1..255.
LOCK_IDLE_MAX, 16, cycles a locked owner may leave req low before the lock is aborted; used only with the optional feature; legal range 1..65535.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester byte-valid; held until ack
last  in  NUM_REQ  per-requester flag: offered byte ends the packet
data  in  8*NUM_REQ  per-requester byte; requester i uses data[8i+7:8i]
ack  out  NUM_REQ  one-cycle pulse: requester's byte accepted
tx_ready  in  1  transmitter idle
tx_isNew  out  1  one-cycle strobe to transmitter
tx_message  out  8  byte to transmitter
owner  out  max(1,clog2(NUM_REQ))  index of current or last grantee
busy  out  1  state != IDLE or lock held
byte_count  out  16  total bytes strobed; wraps 0xFFFF->0
lock_abort  out  1  one-cycle pulse on lock abort (optional feature only; else tied 0)

Behaviour:
- Reset: reset, asynchronous, active-high; clock clock. While reset is high, all registers clear immediately. Reset values: state=IDLE, ptr=0, locked=0, owner=0, tx_isNew=0, tx_message=0x00, ack=0, byte_count=0, lock_abort=0. busy=0 follows from these.
- Reset mid-operation: any in-flight byte is abandoned and any lock is dropped. The transmitter shares the same reset.
- All outputs are registered except busy, which is decoded combinationally from state and locked.
- State machine states: IDLE, WAIT_START, WAIT_DONE.
- IDLE, arbitration candidates: if locked, only the requester at owner is a candidate. Otherwise all requesters are candidates, searched round-robin from ptr upward, wrapping at NUM_REQ-1 to 0.
- IDLE, grant condition: a grant occurs when tx_ready=1 and a candidate has req=1.
- IDLE, grant actions on the clock edge:
  - tx_message <= data of the winner; tx_isNew <= 1; ack[winner] <= 1; owner <= winner.
  - byte_count <= byte_count + 1 (mod 2^16).
  - If last[winner]=1: locked <= 0 and ptr <= (winner+1) mod NUM_REQ.
  - If last[winner]=0: locked <= 1; ptr unchanged.
  - state <= WAIT_START.
- Strobe timing: tx_isNew and ack are high for exactly one cycle, the cycle after the grant edge. They are never asserted back-to-back.
- WAIT_START: a counter starts at 0. Move to WAIT_DONE when tx_ready=0, or when the counter reaches START_WAIT-1 (watchdog).
- WAIT_DONE: move to IDLE when tx_ready=1. The next grant is therefore at least one IDLE cycle later.
- Request sampling: req, last and data are sampled only in IDLE. A requester that drops req before ack loses nothing, and no ack is issued to it.
- Locked owner with req=0 in IDLE: no grant, lock retained, other requesters stay blocked.
- NUM_REQ=1: ptr stays 0 and owner stays 0.

Optional Feature:
LOCK_TIMEOUT_EN
- Defined: while locked and in IDLE, a counter increments each cycle the owner's req=0; it clears whenever the owner's req=1. When the counter reaches LOCK_IDLE_MAX: locked <= 0, ptr <= (owner+1) mod NUM_REQ, lock_abort pulses for one cycle, and no byte is sent.
- Undefined: no counter; the lock persists until the owner sends a byte with last=1, and lock_abort is tied 0.

Test Plan:
1. NUM_REQ=4, req[0]=1, data=0x41, last=1, tx_ready=1 -> the cycle after the grant edge has tx_isNew=1, tx_message=0x41, ack=0001, owner=0; byte_count=1; busy high until tx_ready returns high in WAIT_DONE.
2. req=0111 held, all single-byte (last=1) packets, transmitter model drops ready 2 cycles after strobe for 10 cycles -> grant order 0,1,2,0,1,2 and exactly one ack per strobe.
3. req[1] sends a 3-byte packet 0x10,0x11,0x12 (last on 0x12) while req[0] continuously pending -> tx order 0x10,0x11,0x12 then requester 0's byte; ptr=2 after the packet.
4. Transmitter model never drops tx_ready -> WAIT_START exits after START_WAIT=4 cycles; the next grant follows normally.
5. Reset asserted asynchronously mid-WAIT_DONE with locked=1 -> all outputs 0 before the next clock edge; the first grant after release is searched from requester 0.
6. (LOCK_TIMEOUT_EN) Owner 2 locked, req[2]=0 for 16 cycles, req[3]=1 -> lock_abort pulses once, then requester 3 is granted; byte_count is unchanged by the abort. Without the macro, requester 3 is never granted.
